// File: rtl/block_move_controller.sv
// block_move_controller: draw / hold / erase / move sequencer for the moving
// block. It drives the pixel plotter via a plot_go/plot_done handshake and
// counts video frames only while the block is held on screen.
// Optional feature: define BOUNCE_EN to make the block reverse direction at
// the edges instead of wrapping back to x = 0.
module block_move_controller #(
  parameter int FRAMES_PER_STEP = 15,
  parameter int XW              = 8,
  parameter int STEP            = 4,
  parameter int X_MAX           = 152
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  input  logic          stop,
  input  logic          frame_tick,
  input  logic          plot_done,
  output logic          plot_go,
  output logic          plot_erase,
  output logic [XW-1:0] x_pos,
  output logic          busy,
  output logic          locked
);

  localparam logic [2:0] S_IDLE       = 3'd0;
  localparam logic [2:0] S_DRAW       = 3'd1;
  localparam logic [2:0] S_WAIT_DRAW  = 3'd2;
  localparam logic [2:0] S_HOLD       = 3'd3;
  localparam logic [2:0] S_ERASE      = 3'd4;
  localparam logic [2:0] S_WAIT_ERASE = 3'd5;
  localparam logic [2:0] S_MOVE       = 3'd6;
  localparam logic [2:0] S_LOCKED     = 3'd7;

  localparam logic [XW:0] STEP_W   = (XW+1)'(STEP);
  localparam logic [XW:0] X_MAX_W  = (XW+1)'(X_MAX);
  localparam logic [7:0]  FRAMES_W = 8'(FRAMES_PER_STEP);

  logic [2:0]    state_q, state_d;
  logic [7:0]    frame_cnt_q, frame_cnt_d;
  logic          stop_q, stop_d;
  logic [XW-1:0] x_q, x_d, x_next;
  logic          go_q, go_d;
  logic          erase_q, erase_d;
  logic          busy_q, busy_d;
  logic          locked_q, locked_d;
  logic [XW:0]   x_plus;
`ifdef BOUNCE_EN
  logic [XW:0]   x_minus;
  logic          dir_left_q, dir_left_d, dir_left_next;
`endif

  // Next position, one bit wider than x_pos so the edge test cannot overflow.
  always_comb begin
    x_plus = {1'b0, x_q} + STEP_W;
`ifdef BOUNCE_EN
    x_minus       = {1'b0, x_q} - STEP_W;
    dir_left_next = dir_left_q;
    x_next        = x_plus[XW-1:0];
    if (!dir_left_q) begin
      if (x_plus > X_MAX_W) begin
        dir_left_next = 1'b1;
        x_next        = x_minus[XW-1:0];
      end
    end else if ({1'b0, x_q} < STEP_W) begin
      dir_left_next = 1'b0;
    end else begin
      x_next = x_minus[XW-1:0];
    end
`else
    x_next = (x_plus > X_MAX_W) ? '0 : x_plus[XW-1:0];
`endif
  end

  // Sequencer next-state, frame counting, stop latch and registered outputs.
  always_comb begin
    state_d     = state_q;
    frame_cnt_d = frame_cnt_q;
    stop_d      = stop_q;
    x_d         = x_q;
    locked_d    = 1'b0;
`ifdef BOUNCE_EN
    dir_left_d  = dir_left_q;
`endif
    // stop only sticks while a run is in progress
    if (stop && state_q != S_IDLE && state_q != S_LOCKED) stop_d = 1'b1;

    case (state_q)
      S_IDLE: if (start) begin
        state_d = S_DRAW;
        stop_d  = 1'b0;
      end
      S_DRAW:      state_d = S_WAIT_DRAW;
      S_WAIT_DRAW: if (plot_done) begin
        state_d     = S_HOLD;
        frame_cnt_d = 8'd0;
      end
      S_HOLD: begin
        // a stop (latched or arriving now) beats the final tick: block stays drawn
        if (stop_q || stop) begin
          state_d  = S_LOCKED;
          stop_d   = 1'b0;
          locked_d = 1'b1;
        end else if (frame_tick) begin
          frame_cnt_d = frame_cnt_q + 8'd1;
          if (frame_cnt_q + 8'd1 == FRAMES_W) state_d = S_ERASE;
        end
      end
      S_ERASE:      state_d = S_WAIT_ERASE;
      S_WAIT_ERASE: if (plot_done) state_d = S_MOVE;
      S_MOVE: begin
        x_d     = x_next;
`ifdef BOUNCE_EN
        dir_left_d = dir_left_next;
`endif
        state_d = S_DRAW;
      end
      S_LOCKED: if (start) begin
        state_d = S_DRAW;
        stop_d  = 1'b0;
        x_d     = '0;
`ifdef BOUNCE_EN
        dir_left_d = 1'b0;
`endif
      end
      default: state_d = S_IDLE;
    endcase

    // outputs are decoded from the next state so they are registered
    go_d   = (state_d == S_DRAW) || (state_d == S_ERASE);
    erase_d = erase_q;
    if (state_d == S_ERASE)     erase_d = 1'b1;
    else if (state_d == S_DRAW) erase_d = 1'b0;
    busy_d = (state_d != S_IDLE) && (state_d != S_LOCKED);
  end

  // State and output registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= S_IDLE;
      frame_cnt_q <= 8'd0;
      stop_q      <= 1'b0;
      x_q         <= '0;
      go_q        <= 1'b0;
      erase_q     <= 1'b0;
      busy_q      <= 1'b0;
      locked_q    <= 1'b0;
`ifdef BOUNCE_EN
      dir_left_q  <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      frame_cnt_q <= frame_cnt_d;
      stop_q      <= stop_d;
      x_q         <= x_d;
      go_q        <= go_d;
      erase_q     <= erase_d;
      busy_q      <= busy_d;
      locked_q    <= locked_d;
`ifdef BOUNCE_EN
      dir_left_q  <= dir_left_d;
`endif
    end
  end

  assign plot_go    = go_q;
  assign plot_erase = erase_q;
  assign x_pos      = x_q;
  assign busy       = busy_q;
  assign locked     = locked_q;

endmodule

// File: tb/tb_block_move_controller.sv
// Randomized bench for block_move_controller. A plotter responder answers
// each plot_go after a random delay; a protocol-level model predicts when the
// next plot_go / locked pulse must appear and at which x position.
module tb_block_move_controller;
  localparam int FRAMES = 15;
  localparam int STEP   = 4;
  localparam int X_MAX  = 152;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       start = 1'b0, stop = 1'b0, frame_tick = 1'b0, plot_done = 1'b0;
  logic       plot_go, plot_erase, busy, locked;
  logic [7:0] x_pos;

  block_move_controller #(.FRAMES_PER_STEP(FRAMES), .XW(8), .STEP(STEP), .X_MAX(X_MAX)) dut (
    .clk(clk), .reset(reset), .start(start), .stop(stop), .frame_tick(frame_tick),
    .plot_done(plot_done), .plot_go(plot_go), .plot_erase(plot_erase), .x_pos(x_pos),
    .busy(busy), .locked(locked));

  always #5 clk = ~clk;

  int checks = 0, failures = 0;
  int cyc_n = 0;
  int exp_go_at = -1, exp_lock_at = -1, pend_done_at = -1, restart_at = -1;
  bit exp_go_erase, pend_erase;
  int x_exp = 0;
  bit left_exp = 0;
  bit in_hold = 0, active = 0, stop_pending = 0, spur_go = 0;
  int hold_ticks = 0, start_iter = 0, fixed_dly = 0, locks = 0;
  bit en_stop = 0, en_restart = 0, force_last_stop = 0, force_wait_stop = 0;
  bit saw_erase40 = 0;
  int draws_q[$];

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, act, exp, cyc_n);
    end
  endtask

  // Movement rule applied to plain integers.
  task automatic model_move(inout int x, inout bit left);
`ifdef BOUNCE_EN
    if (!left) begin
      if (x + STEP > X_MAX) begin left = 1; x = x - STEP; end
      else x = x + STEP;
    end else begin
      if (x < STEP) begin left = 0; x = x + STEP; end
      else x = x - STEP;
    end
`else
    x = (x + STEP > X_MAX) ? 0 : x + STEP;
`endif
  endtask

  task automatic observe();
    spur_go = 0;
    if (plot_go || cyc_n == exp_go_at) begin
      chk("go_timing", plot_go, cyc_n == exp_go_at);
      if (plot_go && cyc_n == exp_go_at) begin
        chk("go_erase", plot_erase, exp_go_erase);
        chk("go_x", x_pos, x_exp);
        chk("go_busy", busy, 1);
        if (!exp_go_erase) draws_q.push_back(int'(x_pos));
        else if (x_exp == 40) saw_erase40 = 1;
        pend_erase   = exp_go_erase;
        pend_done_at = cyc_n + ((fixed_dly != 0) ? fixed_dly : int'($urandom_range(1, 4)));
        spur_go      = ($urandom_range(0, 2) == 0);
      end
      exp_go_at = -1;
    end
    if (locked || cyc_n == exp_lock_at) begin
      chk("locked", locked, cyc_n == exp_lock_at);
      if (cyc_n == exp_lock_at) begin
        chk("lock_busy", busy, 0);
        locks++;
      end
      exp_lock_at = -1;
    end
  endtask

  task automatic drive();
    bit t, s;
    start = 0; stop = 0; plot_done = spur_go;
    t = ($urandom_range(0, 2) == 0);
    frame_tick = t;
    if (cyc_n == restart_at) begin
      start = 1; start_iter = cyc_n; active = 1; stop_pending = 0;
      exp_go_at = cyc_n + 1; exp_go_erase = 0; x_exp = 0; left_exp = 0;
      restart_at = -1;
    end
    if (in_hold) begin
      s = en_stop && ($urandom_range(0, 399) == 0);
      if (force_last_stop && t && hold_ticks == FRAMES - 1) begin s = 1; force_last_stop = 0; end
      if ($urandom_range(0, 3) == 0) plot_done = 1;
      if (stop_pending || s) begin
        stop = s; exp_lock_at = cyc_n + 1;
        in_hold = 0; active = 0; stop_pending = 0;
        if (en_restart) restart_at = cyc_n + int'($urandom_range(3, 8));
      end else if (t) begin
        hold_ticks++;
        if (hold_ticks == FRAMES) begin
          exp_go_at = cyc_n + 1; exp_go_erase = 1; in_hold = 0;
        end
      end
    end else if (active && cyc_n > start_iter && en_stop) begin
      s = ($urandom_range(0, 399) == 0);
      if (force_wait_stop && pend_done_at == cyc_n && !pend_erase) begin s = 1; force_wait_stop = 0; end
      if (s) begin stop = 1; stop_pending = 1; end
    end else if (!active && $urandom_range(0, 9) == 0 && cyc_n != start_iter) begin
      stop = 1; // idle/locked: must be ignored
    end
    if (cyc_n == pend_done_at) begin
      chk("erase_held", plot_erase, pend_erase);
      plot_done = 1; pend_done_at = -1;
      if (!pend_erase) begin
        in_hold = 1; hold_ticks = 0;
      end else begin
        exp_go_at = cyc_n + 2; exp_go_erase = 0;
        model_move(x_exp, left_exp);
      end
    end
  endtask

  task automatic tick_cycle();
    @(posedge clk); #1;
    cyc_n++;
    observe();
    drive();
  endtask

  initial begin
    int idx;
    int n;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_go", plot_go, 0);
    chk("rst_erase", plot_erase, 0);
    chk("rst_x", x_pos, 0);
    chk("rst_busy", busy, 0);
    chk("rst_locked", locked, 0);
    reset = 0;

    // Phase A: fixed 3-cycle plotter, run to the erase at x = 40, then reset mid-plot.
    fixed_dly = 3;
    restart_at = cyc_n + 1;
    n = 0;
    while (!saw_erase40 && n < 2000) begin tick_cycle(); n++; end
    chk("erase40_reached", saw_erase40, 1);
    tick_cycle();
    #2 reset = 1;
    #1;
    chk("midrst_go", plot_go, 0);
    chk("midrst_erase", plot_erase, 0);
    chk("midrst_x", x_pos, 0);
    chk("midrst_busy", busy, 0);
    chk("midrst_locked", locked, 0);
    @(posedge clk); #1;
    reset = 0;
    pend_done_at = -1; exp_go_at = -1; in_hold = 0; active = 0; stop_pending = 0;
    plot_done = 1;  // the plotter's stale completion after the reset
    for (int i = 0; i < 8; i++) tick_cycle();
    chk("stale_done_busy", busy, 0);

    // Phase B: random plotter latency, no stops, run past the right edge.
    fixed_dly = 0;
    draws_q.delete();
    restart_at = cyc_n + 2;
    n = 0;
    while (draws_q.size() < 45 && n < 6000) begin tick_cycle(); n++; end
    chk("draws_reached", draws_q.size() >= 45, 1);
    idx = -1;
    for (int i = 1; i + 1 < draws_q.size(); i++)
      if (idx < 0 && draws_q[i] == 152) idx = i;
    chk("edge_found", idx > 0, 1);
    if (idx > 0) begin
      chk("before_edge", draws_q[idx-1], 148);
`ifdef BOUNCE_EN
      chk("after_edge", draws_q[idx+1], 148);
`else
      chk("after_edge", draws_q[idx+1], 0);
`endif
    end

    // Phase C: random stops with restarts, plus the two forced stop corners.
    en_stop = 1; en_restart = 1; force_last_stop = 1; force_wait_stop = 1;
    for (int i = 0; i < 6000; i++) tick_cycle();
    chk("forced_last_stop_used", force_last_stop, 0);
    chk("forced_wait_stop_used", force_wait_stop, 0);
    chk("locks_seen", locks >= 3, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
